uart_tx_framer: RTL and testbench

- UART transmit engine. Accepts one byte per single-cycle load strobe, produced upstream by the rising-edge detector on the write request.
- Serialises the byte onto tx as a fixed 11-bit-time frame: start bit, data LSB first, optional parity, stop padding.
- txrdy tells the host/CPU side when the next load will be accepted.
- Sits beside the receiver in the UART core and shares its baud-count and format controls.

---
 rtl/uart_pkg.sv | 28 ++
 rtl/uart_bit_timer.sv | 27 ++
 rtl/uart_tx_framer.sv | 85 ++++++++
 tb/tb_uart_tx_framer.sv | 155 +++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Constants, state encoding and frame builder shared by the UART transmitter and receiver.
package uart_pkg;

  localparam int FRAME_BITS     = 11;
  localparam int DEFAULT_BAUD_W = 20;
  localparam int MIN_BAUD_K     = 2;

  typedef enum logic {
    IDLE = 1'b0,
    SEND = 1'b1
  } tx_state_t;

  // Bit 0 goes out first; unused trailing positions pad with stop-level 1s.
  function automatic logic [FRAME_BITS-1:0] build_frame(
    input logic [7:0] d,
    input logic       eight,
    input logic       pen,
    input logic       ohel
  );
    logic                  p;
    logic [FRAME_BITS-1:0] f;
    p = (eight ? ^d : ^d[6:0]) ^ ohel;
    if (eight) f = {1'b1, (pen ? p : 1'b1), d, 1'b0};
    else       f = {2'b11, (pen ? p : 1'b1), d[6:0], 1'b0};
    return f;
  endfunction

endpackage

// File: rtl/uart_bit_timer.sv
// Bit-time counter: counts 0..K-1 while enabled and ticks for one cycle at K-1.
module uart_bit_timer
  import uart_pkg::*;
#(
  parameter int BAUD_W = DEFAULT_BAUD_W
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              i_en,
  input  logic [BAUD_W-1:0] i_k,
  output logic              o_tick
);

  logic [BAUD_W-1:0] r_cnt;
  logic              w_last;

  assign w_last = (r_cnt == i_k - BAUD_W'(1));
  assign o_tick = i_en & w_last;

  // Held at zero while disabled so each new bit period starts from a clean count.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)                r_cnt <= '0;
    else if (!i_en || w_last) r_cnt <= '0;
    else                      r_cnt <= r_cnt + BAUD_W'(1);
  end

endmodule

// File: rtl/uart_tx_framer.sv
// UART transmit engine: latches a byte and its format on load, then shifts out an 11-bit-time frame.
// Handshake: load is taken only on a rising edge where txrdy=1; a load seen while txrdy=0 is dropped.
module uart_tx_framer
  import uart_pkg::*;
#(
  parameter int BAUD_W = DEFAULT_BAUD_W
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              load,
  input  logic [7:0]        din,
  input  logic              eight,
  input  logic              pen,
  input  logic              ohel,
  input  logic [BAUD_W-1:0] baud_k,
  output logic              tx,
  output logic              txrdy,
  output logic              o_dbg_state
);

  tx_state_t             r_state;
  tx_state_t             w_next;
  logic [FRAME_BITS-1:0] r_shift;
  logic [FRAME_BITS-1:0] w_frame;
  logic [BAUD_W-1:0]     r_k;
  logic [3:0]            r_bitcnt;
  logic                  r_tx;
  logic                  w_accept;
  logic                  w_tick;
  logic                  w_last_bit;

  assign w_accept   = (r_state == IDLE) && load;
  assign w_last_bit = (r_bitcnt == 4'(FRAME_BITS - 1));
  assign w_frame    = build_frame(din, eight, pen, ohel);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_state <= IDLE;
    else       r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    if (load) w_next = SEND;
      SEND:    if (w_tick && w_last_bit) w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  uart_bit_timer #(.BAUD_W(BAUD_W)) u_bit_timer (
    .clk    (clk),
    .reset  (reset),
    .i_en   (r_state == SEND),
    .i_k    (r_k),
    .o_tick (w_tick)
  );

  // The start bit goes straight to tx on accept; the shifter holds what is still to send.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_tx     <= 1'b1;
      r_shift  <= '0;
      r_k      <= '0;
      r_bitcnt <= '0;
    end else if (w_accept) begin
      r_tx     <= w_frame[0];
      r_shift  <= {1'b1, w_frame[FRAME_BITS-1:1]};
      r_k      <= (baud_k < BAUD_W'(MIN_BAUD_K)) ? BAUD_W'(MIN_BAUD_K) : baud_k;
      r_bitcnt <= '0;
    end else if (r_state == SEND && w_tick) begin
      if (w_last_bit) begin
        r_tx <= 1'b1;
      end else begin
        r_tx     <= r_shift[0];
        r_shift  <= {1'b1, r_shift[FRAME_BITS-1:1]};
        r_bitcnt <= r_bitcnt + 4'd1;
      end
    end
  end

  assign tx          = r_tx;
  assign txrdy       = (r_state == IDLE);
  assign o_dbg_state = r_state;

endmodule

// File: tb/tb_uart_tx_framer.sv
// Directed and randomized frames checked against a bit-list model of the UART frame format.
module tb_uart_tx_framer;
  import uart_pkg::*;

  logic                      clk = 1'b0;
  logic                      reset;
  logic                      load;
  logic [7:0]                din;
  logic                      eight;
  logic                      pen;
  logic                      ohel;
  logic [DEFAULT_BAUD_W-1:0] baud_k;
  logic                      tx;
  logic                      txrdy;
  logic                      dbg_state;

  int vectors     = 0;
  int miscompares = 0;
  logic [0:0] exp_q[$];

  always #5 clk = ~clk;

  uart_tx_framer dut (
    .clk         (clk),
    .reset       (reset),
    .load        (load),
    .din         (din),
    .eight       (eight),
    .pen         (pen),
    .ohel        (ohel),
    .baud_k      (baud_k),
    .tx          (tx),
    .txrdy       (txrdy),
    .o_dbg_state (dbg_state)
  );

  task automatic check(input string tag, input logic obs, input logic exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0b expected %0b", tag, obs, exp);
    end
  endtask

  // Expected line levels, one entry per bit time, built from the frame rules.
  task automatic model(input logic [7:0] d, input logic e, input logic p, input logic o);
    int n;
    int ones;
    exp_q.delete();
    exp_q.push_back(1'b0);
    n    = e ? 8 : 7;
    ones = 0;
    for (int i = 0; i < n; i++) begin
      exp_q.push_back(1'((d >> i) & 1));
      ones += (d >> i) & 1;
    end
    if (p) exp_q.push_back(1'((ones % 2) ^ int'(o)));
    while (exp_q.size() < 11) exp_q.push_back(1'b1);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      check("idle_tx", tx, 1'b1);
      check("idle_txrdy", txrdy, 1'b1);
    end
  endtask

  // Called at a negedge; the load is taken at the following rising edge.
  task automatic send(input logic [7:0] d, input logic e, input logic p, input logic o,
                      input logic [DEFAULT_BAUD_W-1:0] bk, input int disturb_at, input int abort_at);
    int k;
    model(d, e, p, o);
    k      = (bk < 2) ? 2 : int'(bk);
    din    = d;
    eight  = e;
    pen    = p;
    ohel   = o;
    baud_k = bk;
    load   = 1'b1;
    for (int j = 0; j < 11 * k; j++) begin
      @(negedge clk);
      load = 1'b0;
      check($sformatf("tx_bit%0d_clk%0d", j / k, j % k), tx, exp_q[j / k]);
      check($sformatf("txrdy_busy_clk%0d", j), txrdy, 1'b0);
      if (j == abort_at) begin
        reset = 1'b1;
        #1;
        check("reset_async_tx", tx, 1'b1);
        check("reset_async_txrdy", txrdy, 1'b1);
        @(negedge clk);
        check("reset_held_tx", tx, 1'b1);
        check("reset_held_txrdy", txrdy, 1'b1);
        reset = 1'b0;
        return;
      end
      if (j == disturb_at) begin
        load   = 1'b1;
        din    = 8'hFF;
        baud_k = 9;
        eight  = ~e;
        pen    = ~p;
        ohel   = ~o;
      end
    end
    @(negedge clk);
    check("end_tx_idle", tx, 1'b1);
    check("end_txrdy_rise", txrdy, 1'b1);
  endtask

  initial begin
    reset  = 1'b1;
    load   = 1'b0;
    din    = 8'h00;
    eight  = 1'b1;
    pen    = 1'b0;
    ohel   = 1'b0;
    baud_k = 4;
    repeat (3) @(negedge clk);
    check("reset_tx", tx, 1'b1);
    check("reset_txrdy", txrdy, 1'b1);
    reset = 1'b0;
    idle(20);

    send(8'hA5, 1'b1, 1'b1, 1'b0, 4, -1, -1);
    idle(2);
    send(8'h41, 1'b0, 1'b0, 1'b0, 3, -1, -1);
    idle(1);
    send(8'h00, 1'b1, 1'b1, 1'b1, 2, -1, -1);
    send(8'h01, 1'b1, 1'b1, 1'b0, 2, -1, -1);
    send(8'h01, 1'b1, 1'b1, 1'b0, 0, -1, -1);
    idle(1);

    // Mid-frame load and baud change at clock 12 must be dropped.
    send(8'h55, 1'b1, 1'b0, 1'b0, 5, 11, -1);
    idle(3);
    send(8'h96, 1'b0, 1'b1, 1'b1, 1, -1, -1);
    send(8'h5A, 1'b1, 1'b1, 1'b1, 3, -1, -1);

    send(8'hA5, 1'b1, 1'b1, 1'b0, 4, -1, 16);
    idle(2);
    send(8'h3C, 1'b1, 1'b1, 1'b0, 4, -1, -1);

    for (int i = 0; i < 12; i++) begin
      send(8'($urandom), 1'($urandom), 1'($urandom), 1'($urandom),
           DEFAULT_BAUD_W'($urandom_range(0, 6)), -1, -1);
      idle(int'($urandom_range(0, 3)));
    end
    idle(5);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
